// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: shared format codes, opcodes and FSM state for the immediate encoder
package imm_encoder_pkg;
  localparam int XLEN_32B = 1;
  localparam int XLEN_64B = 2;
  localparam logic [2:0] IMM_I_TYPE = 3'd0;
  localparam logic [2:0] IMM_S_TYPE = 3'd1;
  localparam logic [2:0] IMM_B_TYPE = 3'd2;
  localparam logic [2:0] IMM_U_TYPE = 3'd3;
  localparam logic [2:0] IMM_J_TYPE = 3'd4;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI = 3'b000;
  typedef enum logic {IDLE, LI_LO} state_t;
  function automatic int xlen_w(input int xlen);
    return 1 << (xlen + 4);
  endfunction
endpackage

// File: rtl/imm_encoder_field_pack.sv
// imm_field_pack: places an immediate into one instruction format and flags unrepresentable values
module imm_field_pack import imm_encoder_pkg::*; #(
  parameter int W = 64
) (
  input  logic [2:0]   fmt,
  input  logic [31:0]  base,
  input  logic [W-1:0] imm,
  output logic [31:0]  instr,
  output logic         err
);
  logic [W-1:0] s11, s12, s20, s31;
  logic ok11, ok12, ok20, ok31;
  // upper bits are a pure sign extension when the arithmetic shift is all zeros or all ones
  assign s11 = W'($signed(imm) >>> 11);
  assign s12 = W'($signed(imm) >>> 12);
  assign s20 = W'($signed(imm) >>> 20);
  assign s31 = W'($signed(imm) >>> 31);
  assign ok11 = s11 == '0 || &s11;
  assign ok12 = s12 == '0 || &s12;
  assign ok20 = s20 == '0 || &s20;
  assign ok31 = s31 == '0 || &s31;
  always_comb begin
    case (fmt)
      IMM_I_TYPE: begin
        instr = {imm[11:0], base[19:0]};
        err = !ok11;
      end
      IMM_S_TYPE: begin
        instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        err = !ok11;
      end
      IMM_B_TYPE: begin
        instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        err = !ok12 || imm[0];
      end
      IMM_U_TYPE: begin
        instr = {imm[31:12], base[11:0]};
        err = !ok31 || |imm[11:0];
      end
      IMM_J_TYPE: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        err = !ok20 || imm[0];
      end
      default: begin
        instr = base;
        err = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: packs immediates into I/S/B/U/J fields, or expands a 32-bit constant
// into a one- or two-instruction LUI/ADDI sequence, behind a registered valid/ready stage
module imm_encoder import imm_encoder_pkg::*; #(
  parameter int XLEN = XLEN_64B,
  localparam int W = xlen_w(XLEN)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [2:0]   i_imm_ctl,
  input  logic         i_li_mode,
  input  logic [31:0]  i_base_instr,
  input  logic [W-1:0] i_imm,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [31:0]  o_instr,
  output logic         o_err,
  output logic         o_last,
  output logic [7:0]   o_err_cnt
);
  state_t state;
  logic [W-1:0] lui_sum, imm32_sx, s31;
  logic [31:0] fmt_instr, lui_instr, addi_instr, pend_instr, first_instr;
  logic [4:0] rd;
  logic fmt_err, lui_err, addi_err, ok31, li_err, li_two, accept, consume;
  assign rd = i_base_instr[11:7];
  assign lui_sum = i_imm + W'(32'h800);
  assign imm32_sx = W'($signed(i_imm[31:0]));
  assign s31 = W'($signed(i_imm) >>> 31);
  assign ok31 = s31 == '0 || &s31;
  // a rounding carry into bit 31 surfaces as a U-type range error on the LUI half
  assign li_err = lui_err || !ok31;
  // addi_err is set exactly when the rounded upper half is non-zero
  assign li_two = i_li_mode && addi_err && |i_imm[11:0];
  assign first_instr = !i_li_mode ? fmt_instr : addi_err ? lui_instr : addi_instr;
  assign o_ready = state == IDLE && (!o_valid || i_ready);
  assign accept = i_valid && o_ready;
  assign consume = o_valid && i_ready;
  imm_field_pack #(.W(W)) u_fmt (
    .fmt(i_imm_ctl),
    .base(i_base_instr),
    .imm(i_imm),
    .instr(fmt_instr),
    .err(fmt_err)
  );
  imm_field_pack #(.W(W)) u_lui (
    .fmt(IMM_U_TYPE),
    .base({20'h0, rd, OPC_LUI}),
    .imm(lui_sum & ~W'(32'hFFF)),
    .instr(lui_instr),
    .err(lui_err)
  );
  imm_field_pack #(.W(W)) u_addi (
    .fmt(IMM_I_TYPE),
    .base({12'h0, (|lui_sum[31:12]) ? rd : 5'd0, F3_ADDI, rd, OPC_OP_IMM}),
    .imm(imm32_sx),
    .instr(addi_instr),
    .err(addi_err)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      o_valid <= 1'b0;
      o_instr <= '0;
      o_err <= 1'b0;
      o_last <= 1'b0;
      o_err_cnt <= '0;
      pend_instr <= '0;
    end else begin
      if (accept) begin
        o_valid <= 1'b1;
        o_instr <= first_instr;
        o_err <= i_li_mode ? li_err : fmt_err;
        o_last <= !li_two;
        pend_instr <= addi_instr;
        state <= li_two ? LI_LO : IDLE;
      end else if (consume) begin
        o_valid <= state == LI_LO;
        if (state == LI_LO) o_instr <= pend_instr;
        o_last <= 1'b1;
        state <= IDLE;
      end
      if (consume && o_err && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
    end
endmodule
